// File: rtl/fsm_seq_pkg.sv
// fsm_seq_pkg: shared types and helpers for the sequence monitor.
// Holds the monitor state enum, bus widths and the next_seq step function.
package fsm_seq_pkg;

    localparam int SEQ_W   = 3;
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2,
        ALARM  = 2'd3
    } state_e;

    // Next value of the 2-bit cyclic sequence; 3 wraps to 0.
    function automatic logic [1:0] next_seq(input logic [1:0] prev);
        return prev + 2'd1;
    endfunction

endpackage

// File: rtl/fsm_seq_monitor_sat_counter.sv
// sat_counter: W-bit up-counter that saturates at all-ones.
// Ports: clk, rst_n (async low), inc (+1), clr (sync clear, wins), count.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fsm_seq_monitor.sv
// fsm_seq_monitor: receive-side checker for the 0-1-2-3 cyclic sequence.
// In: clk, rst_n, seq_in[2:0], seq_valid, alarm_clr.
// Out: locked, alarm, err_pulse, err_cnt[CNT_W-1:0], exp_state[1:0].
module fsm_seq_monitor
    import fsm_seq_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int ERR_MAX  = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEQ_W-1:0] seq_in,
    input  logic             seq_valid,
    input  logic             alarm_clr,
    output logic             locked,
    output logic             alarm,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       exp_state
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(ERR_MAX + 1);

    state_e            state_q, state_d;
    logic [1:0]        prev_q, prev_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              err_d;

    logic              locked_q, alarm_q, err_pulse_q;
    logic [1:0]        exp_q, exp_d;

    logic [1:0]        expd;
    logic              illegal;
    logic              match;
    logic [RUN_W-1:0]  run_inc;
    logic [MISS_W-1:0] miss_inc;

    assign expd     = next_seq(prev_q);
    assign illegal  = seq_in[2];
    assign match    = !illegal && (seq_in[1:0] == expd);
    assign run_inc  = run_q + 1'b1;
    assign miss_inc = miss_q + 1'b1;

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        run_d   = run_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        if (alarm_clr) begin
            state_d = HUNT;
            run_d   = '0;
            miss_d  = '0;
        end else if (seq_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        prev_d  = seq_in[1:0];
                        run_d   = '0;
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    if (illegal) begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end else if (match) begin
                        run_d  = run_inc;
                        prev_d = seq_in[1:0];
                        if (run_inc == RUN_W'(LOCK_CNT)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        run_d  = '0;
                        prev_d = seq_in[1:0];
                    end
                end
                LOCKED: begin
                    if (match) begin
                        miss_d = '0;
                        prev_d = seq_in[1:0];
                    end else begin
                        // Flywheel: keep the expected cadence
                        // running across bad samples.
                        err_d  = 1'b1;
                        miss_d = miss_inc;
                        prev_d = expd;
                        if (miss_inc == MISS_W'(ERR_MAX)) begin
                            state_d = ALARM;
                        end
                    end
                end
                ALARM: begin
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        exp_d = 2'd0;
        if ((state_d == SYNC) || (state_d == LOCKED)) begin
            exp_d = next_seq(prev_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            prev_q      <= 2'd0;
            run_q       <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            alarm_q     <= 1'b0;
            err_pulse_q <= 1'b0;
            exp_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            locked_q    <= (state_d == LOCKED);
            alarm_q     <= (state_d == ALARM);
            err_pulse_q <= err_d;
            exp_q       <= exp_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (err_d),
        .clr  (alarm_clr),
        .count(err_cnt)
    );

    assign locked    = locked_q;
    assign alarm     = alarm_q;
    assign err_pulse = err_pulse_q;
    assign exp_state = exp_q;

endmodule
